// File: rtl/bf_sequencer.sv
// Brainfuck execution controller: sequences opcodes from external program memory,
// steers the data cursor and write port, and runs byte I/O handshakes.
module bf_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int DEPTH_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        prg,
  input  logic [7:0]        mem,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] cursor,
  output logic [7:0]        out,
  output logic              we,
  output logic [7:0]        io_data,
  output logic              io_valid,
  input  logic              io_ready,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              halted,
  output logic              error
);

  typedef enum logic [3:0] {
    S_LOAD       = 4'd0,
    S_EXEC       = 4'd1,
    S_SKIPF_LOAD = 4'd2,
    S_SKIPF      = 4'd3,
    S_SKIPB_LOAD = 4'd4,
    S_SKIPB      = 4'd5,
    S_OUT_WAIT   = 4'd6,
    S_IN_WAIT    = 4'd7,
    S_HALT       = 4'd8
  } state_t;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_RIGHT = 4'd1;
  localparam logic [3:0] OP_LEFT  = 4'd2;
  localparam logic [3:0] OP_INC   = 4'd3;
  localparam logic [3:0] OP_DEC   = 4'd4;
  localparam logic [3:0] OP_OUT   = 4'd5;
  localparam logic [3:0] OP_IN    = 4'd6;
  localparam logic [3:0] OP_OPEN  = 4'd7;
  localparam logic [3:0] OP_CLOSE = 4'd8;

  localparam logic [ADDR_W-1:0]  ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = {{(DEPTH_W-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = {DEPTH_W{1'b1}};

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   pc_r, pc_s;
  logic [ADDR_W-1:0]   cursor_r, cursor_s;
  logic [7:0]          out_r, out_s;
  logic                we_r, we_s;
  logic [7:0]          io_data_r, io_data_s;
  logic                io_valid_r, io_valid_s;
  logic                in_ready_r, in_ready_s;
  logic                halted_r, halted_s;
  logic                error_r, error_s;
  logic [DEPTH_W-1:0]  depth_r, depth_s;

  assign pc       = pc_r;
  assign cursor   = cursor_r;
  assign out      = out_r;
  assign we       = we_r;
  assign io_data  = io_data_r;
  assign io_valid = io_valid_r;
  assign in_ready = in_ready_r;
  assign halted   = halted_r;
  assign error    = error_r;

  // Next-state and output decode; every register holds unless a branch changes it.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    cursor_s   = cursor_r;
    out_s      = out_r;
    we_s       = 1'b0;
    io_data_s  = io_data_r;
    io_valid_s = io_valid_r;
    in_ready_s = in_ready_r;
    halted_s   = halted_r;
    error_s    = error_r;
    depth_s    = depth_r;

    case (state_r)
      S_LOAD: begin
        state_s = S_EXEC;
      end

      S_EXEC: begin
        case (prg)
          OP_HALT: begin
            halted_s = 1'b1;
            state_s  = S_HALT;
          end
          OP_RIGHT: begin
            cursor_s = cursor_r + ADDR_ONE;
            pc_s     = pc_r + ADDR_ONE;
            state_s  = S_LOAD;
          end
          OP_LEFT: begin
            cursor_s = cursor_r - ADDR_ONE;
            pc_s     = pc_r + ADDR_ONE;
            state_s  = S_LOAD;
          end
          OP_INC: begin
            out_s   = mem + 8'd1;
            we_s    = 1'b1;
            pc_s    = pc_r + ADDR_ONE;
            state_s = S_LOAD;
          end
          OP_DEC: begin
            out_s   = mem - 8'd1;
            we_s    = 1'b1;
            pc_s    = pc_r + ADDR_ONE;
            state_s = S_LOAD;
          end
          OP_OUT: begin
            io_data_s  = mem;
            io_valid_s = 1'b1;
            state_s    = S_OUT_WAIT;
          end
          OP_IN: begin
            in_ready_s = 1'b1;
            state_s    = S_IN_WAIT;
          end
          OP_OPEN: begin
            pc_s = pc_r + ADDR_ONE;
            if (mem == 8'd0) begin
              depth_s = DEPTH_ONE;
              state_s = S_SKIPF_LOAD;
            end else begin
              state_s = S_LOAD;
            end
          end
          OP_CLOSE: begin
            if (mem == 8'd0) begin
              pc_s    = pc_r + ADDR_ONE;
              state_s = S_LOAD;
            end else if (pc_r == ADDR_ZERO) begin
              // a ']' at address 0 can never have a matching '[' before it
              error_s  = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
            end else begin
              depth_s = DEPTH_ONE;
              pc_s    = pc_r - ADDR_ONE;
              state_s = S_SKIPB_LOAD;
            end
          end
          default: begin
            pc_s    = pc_r + ADDR_ONE;
            state_s = S_LOAD;
          end
        endcase
      end

      S_SKIPF_LOAD: begin
        state_s = S_SKIPF;
      end

      S_SKIPF: begin
        case (prg)
          OP_HALT: begin
            error_s  = 1'b1;
            halted_s = 1'b1;
            state_s  = S_HALT;
          end
          OP_OPEN: begin
            if (depth_r == DEPTH_MAX) begin
              error_s  = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
            end else begin
              depth_s = depth_r + DEPTH_ONE;
              pc_s    = pc_r + ADDR_ONE;
              state_s = S_SKIPF_LOAD;
            end
          end
          OP_CLOSE: begin
            depth_s = depth_r - DEPTH_ONE;
            pc_s    = pc_r + ADDR_ONE;
            if (depth_r == DEPTH_ONE) begin
              state_s = S_LOAD;
            end else begin
              state_s = S_SKIPF_LOAD;
            end
          end
          default: begin
            pc_s    = pc_r + ADDR_ONE;
            state_s = S_SKIPF_LOAD;
          end
        endcase
      end

      S_SKIPB_LOAD: begin
        state_s = S_SKIPB;
      end

      S_SKIPB: begin
        case (prg)
          OP_CLOSE: begin
            if ((depth_r == DEPTH_MAX) || (pc_r == ADDR_ZERO)) begin
              error_s  = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
            end else begin
              depth_s = depth_r + DEPTH_ONE;
              pc_s    = pc_r - ADDR_ONE;
              state_s = S_SKIPB_LOAD;
            end
          end
          OP_OPEN: begin
            depth_s = depth_r - DEPTH_ONE;
            if (depth_r == DEPTH_ONE) begin
              pc_s    = pc_r + ADDR_ONE;
              state_s = S_LOAD;
            end else if (pc_r == ADDR_ZERO) begin
              error_s  = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
            end else begin
              pc_s    = pc_r - ADDR_ONE;
              state_s = S_SKIPB_LOAD;
            end
          end
          default: begin
            if (pc_r == ADDR_ZERO) begin
              error_s  = 1'b1;
              halted_s = 1'b1;
              state_s  = S_HALT;
            end else begin
              pc_s    = pc_r - ADDR_ONE;
              state_s = S_SKIPB_LOAD;
            end
          end
        endcase
      end

      S_OUT_WAIT: begin
        if (io_ready) begin
          io_valid_s = 1'b0;
          pc_s       = pc_r + ADDR_ONE;
          state_s    = S_LOAD;
        end else begin
          state_s = S_OUT_WAIT;
        end
      end

      S_IN_WAIT: begin
        if (in_valid) begin
          out_s      = in_data;
          we_s       = 1'b1;
          in_ready_s = 1'b0;
          pc_s       = pc_r + ADDR_ONE;
          state_s    = S_LOAD;
        end else begin
          state_s = S_IN_WAIT;
        end
      end

      S_HALT: begin
        state_s = S_HALT;
      end

      default: begin
        // unreachable encoding: stop safely and flag it
        error_s  = 1'b1;
        halted_s = 1'b1;
        state_s  = S_HALT;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_LOAD;
      pc_r       <= ADDR_ZERO;
      cursor_r   <= ADDR_ZERO;
      out_r      <= 8'd0;
      we_r       <= 1'b0;
      io_data_r  <= 8'd0;
      io_valid_r <= 1'b0;
      in_ready_r <= 1'b0;
      halted_r   <= 1'b0;
      error_r    <= 1'b0;
      depth_r    <= {DEPTH_W{1'b0}};
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      cursor_r   <= cursor_s;
      out_r      <= out_s;
      we_r       <= we_s;
      io_data_r  <= io_data_s;
      io_valid_r <= io_valid_s;
      in_ready_r <= in_ready_s;
      halted_r   <= halted_s;
      error_r    <= error_s;
      depth_r    <= depth_s;
    end
  end

endmodule

// File: tb/tb_bf_sequencer.sv
// Bench for bf_sequencer: behavioural program/data RAMs, byte-output scoreboard,
// and one task per scenario.
module tb_bf_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  prg;
  logic [7:0]  mem;
  logic [15:0] pc;
  logic [15:0] cursor;
  logic [7:0]  out;
  logic        we;
  logic [7:0]  io_data;
  logic        io_valid;
  logic        io_ready;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        halted;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] prog [0:65535];
  logic [7:0] dmem [0:65535];
  logic [7:0] exp_q [$];

  bf_sequencer #(.ADDR_W(16), .DEPTH_W(16)) dut (
    .clk(clk), .reset(reset), .prg(prg), .mem(mem), .pc(pc), .cursor(cursor),
    .out(out), .we(we), .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .halted(halted), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous RAMs with registered reads; data RAM is write-first at the cursor.
  always @(posedge clk) begin
    prg <= prog[pc];
    if (we) begin
      dmem[cursor] <= out;
      mem          <= out;
    end else begin
      mem <= dmem[cursor];
    end
  end

  // Scoreboard consumer: a transfer fires at the next edge when both are high.
  always @(negedge clk) begin
    if (!reset && io_valid && io_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL io_byte: got unexpected 0x%02h, required none", io_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (io_data !== e) begin
          mismatched++;
          $display("FAIL io_byte: got 0x%02h, required 0x%02h", io_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] op_of(input byte c);
    case (c)
      8'h3E:   return 4'd1;
      8'h3C:   return 4'd2;
      8'h2B:   return 4'd3;
      8'h2D:   return 4'd4;
      8'h2E:   return 4'd5;
      8'h2C:   return 4'd6;
      8'h5B:   return 4'd7;
      8'h5D:   return 4'd8;
      default: return 4'd9;
    endcase
  endfunction

  // Holds reset, loads a fresh program with zeroed data, then releases reset.
  task automatic start_prog(input string s);
    reset = 1'b1;
    tick();
    for (int i = 0; i < 65536; i++) begin
      prog[i] = 4'd0;
      dmem[i] = 8'd0;
    end
    for (int i = 0; i < s.len(); i++) prog[i] = op_of(s[i]);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
  endtask

  task automatic test_reset();
    io_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    reset = 1'b1;
    tick();
    tick();
    compared++;
    if ({pc, cursor, out, we, io_data, io_valid, in_ready, halted, error} !== 60'd0) begin
      mismatched++;
      $display("FAIL reset_state: got pc=%h cur=%h out=%h we=%b iod=%h iov=%b inr=%b h=%b e=%b, required all 0",
               pc, cursor, out, we, io_data, io_valid, in_ready, halted, error);
    end
  endtask

  task automatic test_basic();
    int cyc;
    io_ready = 1'b1;
    start_prog("+++.");
    exp_q.push_back(8'h03);
    cyc = 0;
    for (int i = 0; i < 50 && !io_valid; i++) begin
      tick();
      cyc++;
    end
    // three 2-cycle '+' then LOAD; EXEC '.' registers io_valid at the 8th edge
    compared++;
    if (cyc != 8) begin
      mismatched++;
      $display("FAIL basic_latency: io_valid after %0d edges, required 8", cyc);
    end
    wait_halt(50);
    compared++;
    if (halted !== 1'b1 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL basic_halt: got halted=%b error=%b, required 1/0", halted, error);
    end
    compared++;
    if (dmem[0] !== 8'h03) begin
      mismatched++;
      $display("FAIL basic_mem0: got 0x%02h, required 0x03", dmem[0]);
    end
    tick();
    compared++;
    if (we !== 1'b0) begin
      mismatched++;
      $display("FAIL halt_we: got %b, required 0", we);
    end
  endtask

  task automatic test_wrap();
    io_ready = 1'b1;
    start_prog("<-.");
    exp_q.push_back(8'hFF);
    wait_halt(100);
    compared++;
    if (cursor !== 16'hFFFF) begin
      mismatched++;
      $display("FAIL wrap_cursor: got 0x%04h, required 0xffff", cursor);
    end
    compared++;
    if (dmem[16'hFFFF] !== 8'hFF) begin
      mismatched++;
      $display("FAIL wrap_mem: got 0x%02h, required 0xff", dmem[16'hFFFF]);
    end
  endtask

  task automatic test_loop();
    io_ready = 1'b1;
    start_prog("++[->+<]>.");
    exp_q.push_back(8'h02);
    wait_halt(500);
    compared++;
    if (cursor !== 16'h0001 || dmem[0] !== 8'h00 || dmem[1] !== 8'h02) begin
      mismatched++;
      $display("FAIL loop_state: got cursor=%h m0=%h m1=%h, required 0001/00/02",
               cursor, dmem[0], dmem[1]);
    end
    compared++;
    if (halted !== 1'b1 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL loop_halt: got halted=%b error=%b, required 1/0", halted, error);
    end
  endtask

  task automatic test_skip_and_stall();
    io_ready = 1'b0;
    start_prog("[+[+]]+.");
    exp_q.push_back(8'h01);
    for (int i = 0; i < 100 && !io_valid; i++) tick();
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (io_valid !== 1'b1 || io_data !== 8'h01 || pc !== 16'd7) begin
        mismatched++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h pc=%h, required 1/01/0007",
                 i, io_valid, io_data, pc);
      end
      tick();
    end
    io_ready = 1'b1;
    wait_halt(50);
    compared++;
    if (halted !== 1'b1 || error !== 1'b0 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL skip_end: got halted=%b error=%b pending=%0d, required 1/0/0",
               halted, error, exp_q.size());
    end
  endtask

  task automatic test_input();
    io_ready = 1'b1;
    in_valid = 1'b0;
    start_prog(",+.");
    exp_q.push_back(8'h42);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (in_ready !== 1'b1 || we !== 1'b0) begin
        mismatched++;
        $display("FAIL in_wait[%0d]: got in_ready=%b we=%b, required 1/0", i, in_ready, we);
      end
      tick();
    end
    in_data  = 8'h41;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    compared++;
    if (in_ready !== 1'b0 || we !== 1'b1 || out !== 8'h41) begin
      mismatched++;
      $display("FAIL in_accept: got in_ready=%b we=%b out=%h, required 0/1/41", in_ready, we, out);
    end
    wait_halt(50);
    compared++;
    if (exp_q.size() != 0 || halted !== 1'b1) begin
      mismatched++;
      $display("FAIL in_end: got pending=%0d halted=%b, required 0/1", exp_q.size(), halted);
    end
  endtask

  task automatic test_error();
    io_ready = 1'b1;
    start_prog("+]");
    wait_halt(50);
    compared++;
    if (error !== 1'b1 || halted !== 1'b1) begin
      mismatched++;
      $display("FAIL back_error: got error=%b halted=%b, required 1/1", error, halted);
    end
  endtask

  task automatic test_reset_in_skip();
    io_ready = 1'b1;
    start_prog(">[++++++++]+.");
    for (int i = 0; i < 7; i++) tick();
    compared++;
    if (cursor !== 16'h0001 || halted !== 1'b0) begin
      mismatched++;
      $display("FAIL pre_reset: got cursor=%h halted=%b, required 0001/0", cursor, halted);
    end
    reset = 1'b1;
    tick();
    compared++;
    if (pc !== 16'd0 || cursor !== 16'd0 || we !== 1'b0 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL skip_reset: got pc=%h cursor=%h we=%b error=%b, required 0/0/0/0",
               pc, cursor, we, error);
    end
    reset = 1'b0;
    exp_q.push_back(8'h01);
    wait_halt(200);
    compared++;
    if (dmem[1] !== 8'h01 || exp_q.size() != 0 || error !== 1'b0) begin
      mismatched++;
      $display("FAIL rerun: got m1=%h pending=%0d error=%b, required 01/0/0",
               dmem[1], exp_q.size(), error);
    end
  endtask

  initial begin
    reset = 1'b1; io_ready = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    test_reset();
    test_basic();
    test_wrap();
    test_loop();
    test_skip_and_stall();
    test_input();
    test_error();
    test_reset_in_skip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
